// File: rtl/tdec_wrap_crc_chk.sv
// Decoder CRC checker: CRC16 / CRC24A / CRC24B over MSB-first beats.
// Optional err_cnt output when TDEC_CRC_ERRCNT_EN is defined.
module tdec_wrap_crc_chk #(
  parameter int DW  = 32,
  parameter int NBW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     crc_sel,
  input  logic           din_vld,
  input  logic [DW-1:0]  din,
  input  logic           din_last,
  input  logic [NBW-1:0] din_nbyte,
  output logic           crc_done,
  output logic           crc_ok,
  output logic [23:0]    crc_val,
`ifdef TDEC_CRC_ERRCNT_EN
  output logic [15:0]    err_cnt,
`endif
  output logic           busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // CRC16 runs top-aligned in the 24-bit register; low byte stays zero
  function automatic logic [23:0] poly_of(input logic [1:0] s);
    unique case (s)
      2'd0:    poly_of = 24'h102100;
      2'd2:    poly_of = 24'h800063;
      default: poly_of = 24'h864CFB;
    endcase
  endfunction

  function automatic logic [23:0] crc_beat(
    input logic [23:0]    c,
    input logic [23:0]    p,
    input logic [DW-1:0]  d,
    input logic           last,
    input logic [NBW-1:0] nb
  );
    logic [23:0] r;
    logic        fb;
    r = c;
    for (int k = 0; k < DW; k++) begin
      if (!last || nb == '0 || (k / 8) < int'(nb)) begin
        fb = r[23] ^ d[DW-1-k];
        r  = {r[22:0], 1'b0} ^ (fb ? p : 24'h0);
      end
    end
    return r;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [23:0] crc_q, crc_d;
  logic [1:0]  sel_q, sel_d;
  logic [23:0] val_q, val_d;
  logic        ok_q, ok_d;
  logic [1:0]  sel_eff;
  logic        acc;
  logic        fin;
  logic [23:0] crc_nxt;

  always_comb begin
    sel_eff = start ? crc_sel : sel_q;
    acc     = din_vld && (start || state_q == CALC);
    fin     = acc && din_last;
    crc_nxt = crc_beat(start ? 24'h0 : crc_q, poly_of(sel_eff),
                       din, din_last, din_nbyte);
    state_d = state_q;
    crc_d   = crc_q;
    sel_d   = sel_q;
    val_d   = val_q;
    ok_d    = ok_q;
    if (start) begin
      sel_d   = crc_sel;
      crc_d   = acc ? crc_nxt : 24'h0;
      state_d = fin ? DONE : CALC;
    end else begin
      unique case (state_q)
        CALC: begin
          if (acc) crc_d = crc_nxt;
          if (fin) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    if (fin) begin
      val_d = (sel_eff == 2'd0) ? {8'h0, crc_nxt[23:8]} : crc_nxt;
      ok_d  = (crc_nxt == 24'h0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      crc_q   <= 24'h0;
      sel_q   <= 2'd0;
      val_q   <= 24'h0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      sel_q   <= sel_d;
      val_q   <= val_d;
      ok_q    <= ok_d;
    end
  end

  assign crc_done = (state_q == DONE);
  assign busy     = (state_q == CALC);
  assign crc_val  = val_q;
  assign crc_ok   = ok_q;

`ifdef TDEC_CRC_ERRCNT_EN
  logic [15:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (fin && crc_nxt != 24'h0 && err_q != 16'hFFFF) err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 16'h0;
    else        err_q <= err_d;
  end

  assign err_cnt = err_q;
`endif

endmodule

// File: doc/tdec_wrap_crc_chk.md
TDEC_WRAP_CRC_CHK -- requirements
Module: tdec_wrap_crc_chk

Interface
REQ-001 SHALL have parameter DW, default 32, data beat width in bits; legal values 8, 16, 32.
REQ-002 SHALL have parameter NBW, default 2, width of din_nbyte; NBW = log2(DW/8), minimum 1.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse; begins a new code block and latches crc_sel.
REQ-006 SHALL have port crc_sel  input  2  polynomial select: 0 = CRC16 (0x1021); 1 = CRC24A (0x864CFB); 2 = CRC24B (0x800063); 3 = treated as CRC24A.
REQ-007 SHALL have port din_vld  input  1  beat valid; no backpressure.
REQ-008 SHALL have port din  input  DW  data beat; din[DW-1] is the first bit in time.
REQ-009 SHALL have port din_last  input  1  qualifies the final beat of the block.
REQ-010 SHALL have port din_nbyte  input  NBW  valid bytes on the last beat, MSB-aligned; 0 means all DW/8 bytes valid.
REQ-011 SHALL have port crc_done  output  1  one-cycle pulse when the result is valid.
REQ-012 SHALL have port crc_ok  output  1  remainder equals zero; valid from crc_done onward.
REQ-013 SHALL have port crc_val  output  24  final remainder; CRC16 zero-extended in bits [23:16].
REQ-014 SHALL have port busy  output  1  high while in CALC.

Function
REQ-015 SHALL use a state machine with states IDLE, CALC and DONE.
REQ-016 SHALL transition as follows: IDLE->CALC on start; CALC->DONE on din_vld&din_last; DONE->IDLE unconditionally after one cycle; start in any state->CALC.
REQ-017 SHALL initialise the register to zero on start, MSB-first, non-reflected, with no final XOR.
REQ-018 SHALL treat a beat presented with start in the same cycle as the first beat, computed from the zero init.
REQ-019 SHALL accept one beat per cycle in CALC; din_vld in IDLE or DONE is ignored.
REQ-020 SHALL process only the top din_nbyte bytes on a last beat and ignore the remaining bytes.
REQ-021 SHALL ignore din_nbyte on non-last beats.
REQ-022 SHALL assert crc_done exactly 1 cycle after the last beat is accepted (DONE state).
REQ-023 SHALL update crc_val and crc_ok in that same cycle and hold them until the next start.
REQ-024 SHALL compute crc_ok = (remainder == 0); feeding data plus appended parity yields crc_ok = 1.
REQ-025 SHALL abort the current block on start while in CALC or DONE, produce no crc_done for the aborted block, and reinitialise.
REQ-026 SHALL give start priority over din_last in the same cycle: the beat is the first beat of the new block, and the block completes if din_last is set.
REQ-027 SHALL use crc_sel only as latched at start; changes mid-block have no effect.
REQ-028 SHALL present a last beat with start and din_last together as a single-beat block, with crc_done on the next cycle.

Reset
REQ-029 SHALL, on rst_n low at a clock edge: state=IDLE, CRC register=0, crc_done=0, crc_ok=0, crc_val=0, busy=0, latched crc_sel=0.
REQ-030 SHALL discard an in-flight block on reset mid-block, with no crc_done after reset release.

Configuration
REQ-031 SHALL, when TDEC_CRC_ERRCNT_EN is defined, add output err_cnt[15:0]: increments on each crc_done with crc_ok=0 and saturates at 0xFFFF.
REQ-032 SHALL clear err_cnt only by reset.
REQ-033 SHALL, when TDEC_CRC_ERRCNT_EN is undefined, contain no err_cnt port and no counter logic.

Verification
REQ-034 SHALL verify CRC16: DW=8, "123456789" (0x31..0x39, last on 0x39) -> crc_done 1 cycle later, crc_val=0x0031C3, crc_ok=0.
REQ-035 SHALL verify CRC24A partial beat: DW=32, "123456789" as 3 beats, last beat din_nbyte=1 -> crc_val=0xCDE703.
REQ-036 SHALL verify CRC24B: same stimulus with crc_sel=2 -> crc_val=0x23EF52.
REQ-037 SHALL verify zero remainder: CRC16 DW=8, "123456789" followed by bytes 0x31, 0xC3 -> crc_val=0, crc_ok=1; with err_cnt enabled, err_cnt unchanged.
REQ-038 SHALL verify abort: start mid-block, then a fresh "123456789" CRC24A -> exactly one crc_done with crc_val=0xCDE703.
REQ-039 SHALL verify reset and saturation: rst_n low mid-block -> all outputs 0, no crc_done; err_cnt preloaded via 65536 failing blocks stays 0xFFFF on a further failure.
